// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples sclk/lrclk/sd on clk_i2s and emits 24-bit-slot stereo words.
// Define I2S_RX_ERR_EN to enable the half-frame length check and rx_err strobe.
module i2s_rx #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_BITS  = 24,
    parameter int FRAME_BITS = 32
) (
    input  logic                  clk_i2s,
    input  logic                  reset_n,
    input  logic                  rx_sclk,
    input  logic                  rx_lrclk,
    input  logic                  rx_sd,
    output logic [DATA_WIDTH-1:0] rx_data_l,
    output logic [DATA_WIDTH-1:0] rx_data_r,
    output logic                  rx_valid,
    output logic                  rx_err
);

`ifdef I2S_RX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [5:0] SLOT_CNT  = 6'(SLOT_BITS);
    localparam logic [6:0] FRAME_CNT = 7'(FRAME_BITS);

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    logic                  r_sclkS1, r_sclkS2, r_sclkS3;
    logic                  r_lrS1, r_lrS2, r_lrPrev;
    logic                  r_sdS1, r_sdS2;
    logic [5:0]            r_bitCnt;
    logic [SLOT_BITS-1:0]  r_shift;
    logic [DATA_WIDTH-1:0] r_holdL;
    logic                  r_holdValid;
    state_t                r_state;

    logic                  w_sclkRise;
    logic                  w_lrChg;
    logic [5:0]            w_bitCntNext;
    logic [SLOT_BITS-1:0]  w_shiftNext;
    logic                  w_shiftEn;
    logic                  w_complete;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_lenBad;

    assign w_sclkRise   = r_sclkS2 & ~r_sclkS3;
    assign w_lrChg      = r_lrS2 != r_lrPrev;
    assign w_bitCntNext = w_lrChg ? 6'd0 : ((r_bitCnt == 6'd63) ? r_bitCnt : r_bitCnt + 6'd1);
    assign w_shiftNext  = {r_shift[SLOT_BITS-2:0], r_sdS2};
    assign w_shiftEn    = (w_bitCntNext != 6'd0) && (w_bitCntNext <= SLOT_CNT);
    assign w_complete   = !w_lrChg && (w_bitCntNext == SLOT_CNT);
    assign w_word       = w_shiftNext[SLOT_BITS-1 -: DATA_WIDTH];
    // Half-frame length is the count reached before the lrclk edge, plus the delay slot.
    assign w_lenBad     = ERR_EN && (({1'b0, r_bitCnt} + 7'd1) != FRAME_CNT);

    always_ff @(posedge clk_i2s) begin
        if (!reset_n) begin
            r_sclkS1    <= 1'b0;
            r_sclkS2    <= 1'b0;
            r_sclkS3    <= 1'b0;
            r_lrS1      <= 1'b0;
            r_lrS2      <= 1'b0;
            r_lrPrev    <= 1'b0;
            r_sdS1      <= 1'b0;
            r_sdS2      <= 1'b0;
            r_bitCnt    <= 6'd0;
            r_shift     <= '0;
            r_holdL     <= '0;
            r_holdValid <= 1'b0;
            r_state     <= SYNC;
            rx_data_l   <= '0;
            rx_data_r   <= '0;
            rx_valid    <= 1'b0;
            rx_err      <= 1'b0;
        end else begin
            r_sclkS1 <= rx_sclk;
            r_sclkS2 <= r_sclkS1;
            r_sclkS3 <= r_sclkS2;
            r_lrS1   <= rx_lrclk;
            r_lrS2   <= r_lrS1;
            r_sdS1   <= rx_sd;
            r_sdS2   <= r_sdS1;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (w_sclkRise) begin
                r_lrPrev <= r_lrS2;
                r_bitCnt <= w_bitCntNext;
                if (w_shiftEn) begin
                    r_shift <= w_shiftNext;
                end
                if (w_lrChg) begin
                    // Entering a left slot always invalidates the held left word.
                    if (r_state == SYNC) begin
                        if (!r_lrS2) begin
                            r_state     <= LEFT;
                            r_holdValid <= 1'b0;
                        end
                    end else if (w_lenBad) begin
                        rx_err      <= 1'b1;
                        r_state     <= SYNC;
                        r_holdValid <= 1'b0;
                    end else if (!r_lrS2) begin
                        r_state     <= LEFT;
                        r_holdValid <= 1'b0;
                    end else begin
                        r_state <= RIGHT;
                    end
                end else if (w_complete) begin
                    case (r_state)
                        LEFT: begin
                            r_holdL     <= w_word;
                            r_holdValid <= 1'b1;
                        end
                        RIGHT: begin
                            if (r_holdValid) begin
                                rx_data_l <= r_holdL;
                                rx_data_r <= w_word;
                                rx_valid  <= 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Randomized bench for i2s_rx: drives I2S half-frames and checks against a slot-level model.
`timescale 1ns/1ps
module tb_i2s_rx;

`ifdef I2S_RX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int H = 22;

    logic        clk_i2s = 1'b0;
    logic        reset_n;
    logic        rx_sclk;
    logic        rx_lrclk;
    logic        rx_sd;
    logic [15:0] rx_data_l;
    logic [15:0] rx_data_r;
    logic        rx_valid;
    logic        rx_err;

    int          vectors = 0;
    int          miscompares = 0;
    int          expErr = 0;
    int          obsErr = 0;
    logic [31:0] expQ[$];
    logic [31:0] monExp;

    bit          synced = 0;
    bit          haveLeft = 0;
    logic [15:0] leftWord = '0;
    logic        prevLr = 1'b0;
    int          prevLen = 0;
    logic [15:0] finalL = '0;
    logic [15:0] finalR = '0;

    i2s_rx dut (
        .clk_i2s  (clk_i2s),
        .reset_n  (reset_n),
        .rx_sclk  (rx_sclk),
        .rx_lrclk (rx_lrclk),
        .rx_sd    (rx_sd),
        .rx_data_l(rx_data_l),
        .rx_data_r(rx_data_r),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    always #5 clk_i2s = ~clk_i2s;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Every valid strobe must match the oldest pair the model predicted.
    always @(negedge clk_i2s) begin
        if (rx_err) obsErr++;
        if (rx_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("validWithNothingPending", 32'(rx_valid), 32'd0);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("dataL", 32'(rx_data_l), 32'(monExp[31:16]));
                checkOutput("dataR", 32'(rx_data_r), 32'(monExp[15:0]));
            end
        end
    end

    task automatic applyStimulus(input logic lr, input logic [23:0] slot, input int n, input int resetAt);
        if (lr != prevLr) begin
            if (!synced) begin
                if (!lr) begin
                    synced   = 1;
                    haveLeft = 0;
                end
            end else if (ERR_EN && prevLen != 32) begin
                expErr++;
                synced   = 0;
                haveLeft = 0;
            end else if (!lr) begin
                haveLeft = 0;
            end
        end
        prevLr = lr;
        if (resetAt >= 0) begin
            synced   = 0;
            haveLeft = 0;
            finalL   = '0;
            finalR   = '0;
        end else if (synced && n >= 25) begin
            if (!lr) begin
                haveLeft = 1;
                leftWord = slot[23:8];
            end else if (haveLeft) begin
                expQ.push_back({leftWord, slot[23:8]});
                finalL = leftWord;
                finalR = slot[23:8];
            end
        end
        prevLen = n;

        for (int k = 0; k < n; k++) begin
            rx_sclk = 1'b0;
            if (k == 0) rx_lrclk = lr;
            rx_sd = (k >= 1 && k <= 24) ? slot[24-k] : 1'($urandom_range(0, 1));
            if (k == resetAt) begin
                @(negedge clk_i2s);
                reset_n = 1'b0;
                @(negedge clk_i2s);
                checkOutput("midResetDataL", 32'(rx_data_l), 32'd0);
                checkOutput("midResetDataR", 32'(rx_data_r), 32'd0);
                checkOutput("midResetValid", 32'(rx_valid), 32'd0);
                reset_n = 1'b1;
            end
            #H;
            rx_sclk = 1'b1;
            #H;
        end
    endtask

    task automatic sendFrame(input logic [23:0] l, input logic [23:0] r, input int nl, input int nr);
        applyStimulus(1'b0, l, nl, -1);
        applyStimulus(1'b1, r, nr, -1);
    endtask

    initial begin
        reset_n  = 1'b0;
        rx_sclk  = 1'b0;
        rx_lrclk = 1'b0;
        rx_sd    = 1'b0;
        repeat (3) @(negedge clk_i2s);
        checkOutput("resetDataL", 32'(rx_data_l), 32'd0);
        checkOutput("resetDataR", 32'(rx_data_r), 32'd0);
        checkOutput("resetValid", 32'(rx_valid), 32'd0);
        checkOutput("resetErr", 32'(rx_err), 32'd0);
        reset_n = 1'b1;

        // Start partway through a left slot: nothing may come out of this frame.
        applyStimulus(1'b0, 24'($urandom), 15, -1);
        applyStimulus(1'b1, 24'($urandom), 32, -1);

        sendFrame({16'hdead, 8'($urandom)}, {16'hbeef, 8'($urandom)}, 32, 32);
        sendFrame({16'hdead, 8'($urandom)}, {16'hbeef, 8'($urandom)}, 32, 32);
        sendFrame({16'h0001, 8'($urandom)}, {16'h8000, 8'($urandom)}, 32, 32);
        sendFrame({16'h7fff, 8'($urandom)}, {16'hffff, 8'($urandom)}, 32, 32);
        sendFrame({16'h1234, 8'hff}, {16'h1234, 8'hff}, 32, 32);

        // Reset pulse in the middle of a right slot.
        applyStimulus(1'b0, 24'($urandom), 32, -1);
        applyStimulus(1'b1, 24'($urandom), 32, 10);
        sendFrame(24'($urandom), 24'($urandom), 32, 32);
        sendFrame(24'($urandom), 24'($urandom), 32, 32);

        // Odd-length and short left slots.
        sendFrame(24'($urandom), 24'($urandom), 30, 32);
        sendFrame(24'($urandom), 24'($urandom), 32, 32);
        sendFrame(24'($urandom), 24'($urandom), 32, 32);
        sendFrame(24'($urandom), 24'($urandom), 20, 32);
        sendFrame(24'($urandom), 24'($urandom), 32, 32);

        for (int f = 0; f < 10; f++) begin
            if (ERR_EN)
                sendFrame(24'($urandom), 24'($urandom), 32, 32);
            else
                sendFrame(24'($urandom), 24'($urandom),
                          int'($urandom_range(25, 40)), int'($urandom_range(25, 40)));
        end

        repeat (50) @(negedge clk_i2s);
        checkOutput("pendingPairs", 32'(expQ.size()), 32'd0);
        checkOutput("errCount", 32'(obsErr), 32'(expErr));
        checkOutput("holdL", 32'(rx_data_l), 32'(finalL));
        checkOutput("holdR", 32'(rx_data_r), 32'(finalR));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
